// File: rtl/booth_sequential_multiplier.sv
// Multi-cycle signed multiplier using radix-2 Booth recoding, one step per clock.
// Handshake: start (sampled in IDLE) -> busy for WIDTH+1 cycles -> one-cycle done pulse.
module booth_sequential_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_q;
  logic             r_qm1;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH:0]   w_msx;
  logic [WIDTH:0]   w_a_sum;
  logic [WIDTH:0]   w_a_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_qm1_next;
  logic             w_last_step;

  // The extra accumulator bit keeps A-M exact when M is the most-negative value.
  assign w_msx = {r_m[WIDTH-1], r_m};

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_a_sum = r_a;
    case ({r_q[0], r_qm1})
      2'b10:   w_a_sum = r_a - w_msx;
      2'b01:   w_a_sum = r_a + w_msx;
      default: w_a_sum = r_a;
    endcase
  end

  // Arithmetic right shift of {A, Q, q_minus1}: A's MSB replicates, the old q_minus1 drops out.
  assign {w_a_next, w_q_next, w_qm1_next} = {w_a_sum[WIDTH], w_a_sum, r_q};
  assign w_last_step = (r_count == CNT_W'(WIDTH - 1));

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (w_last_step) w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_a        <= '0;
      r_m        <= '0;
      r_q        <= '0;
      r_qm1      <= 1'b0;
      r_count    <= '0;
      product_hi <= '0;
      product_lo <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m     <= multiplicand;
            r_q     <= multiplier;
            r_a     <= '0;
            r_qm1   <= 1'b0;
            r_count <= '0;
          end
        end
        S_RUN: begin
          r_a     <= w_a_next;
          r_q     <= w_q_next;
          r_qm1   <= w_qm1_next;
          r_count <= r_count + CNT_W'(1);
          // The product fits in 2*WIDTH bits, so A's guard bit is simply dropped.
          if (w_last_step) begin
            product_hi <= w_a_next[WIDTH-1:0];
            product_lo <= w_q_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_sequential_multiplier.sv
// Scoreboard bench for booth_sequential_multiplier: stimulus pushes reference products,
// a monitor pops and compares on every done pulse.
module tb_booth_sequential_multiplier;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];

  booth_sequential_multiplier #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .busy        (busy),
    .done        (done),
    .product_hi  (product_hi),
    .product_lo  (product_lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: exact signed product of the two operands, widened to 2*W bits.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] m, input logic [W-1:0] q);
    logic signed [2*W-1:0] ms;
    logic signed [2*W-1:0] qs;
    ms = {{W{m[W-1]}}, m};
    qs = {{W{q[W-1]}}, q};
    return ms * qs;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard, and checks pulse width.
  initial begin
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (prev_done) check("done_pulse_width", 2, 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done with hi=0x%h lo=0x%h, expected none", product_hi, product_lo);
        end else begin
          check("product", {product_hi, product_lo}, exp_q.pop_front());
        end
      end
      prev_done = (done === 1'b1);
    end
  end

  // Presents start for exactly one edge; the DUT must be IDLE so that edge accepts it.
  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q);
    @(posedge clock); #1;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    exp_q.push_back(ref_prod(m, q));
    @(posedge clock); #1;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (busy === 1'b0) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_idle: busy still high after 200 cycles, expected idle");
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 9))
      0:       v = '0;
      1:       v = W'(1);
      2:       v = '1;
      3:       v = {1'b1, {(W-1){1'b0}}};
      4:       v = {1'b0, {(W-1){1'b1}}};
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int busy_cycles;
    int done_at;

    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", {product_hi, product_lo}, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // 6 x 7: busy spans RUN+DONE = 33 cycles, done in the last of them.
    issue(W'(6), W'(7));
    busy_cycles = 0;
    done_at     = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (busy !== 1'b1) break;
      busy_cycles++;
      if (done === 1'b1) done_at = busy_cycles;
    end
    check("busy_cycles", busy_cycles, 33);
    check("done_position", done_at, 33);
    check("hold_after_done", {product_hi, product_lo}, 64'h0000_0000_0000_002A);

    issue(32'hFFFF_FFFD, W'(5));
    wait_idle();
    issue(32'h8000_0000, 32'h8000_0000);
    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();

    // Start re-asserted mid-operation must be ignored, operands not re-latched.
    issue(W'(6), W'(7));
    repeat (9) @(posedge clock);
    #1;
    multiplicand = W'(1);
    multiplier   = W'(1);
    start        = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_idle();
    check("outstanding_after_busy_start", exp_q.size(), 0);

    // Mid-run reset aborts: no done, outputs cleared.
    issue(W'(6), W'(7));
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", {product_hi, product_lo}, 0);
    repeat (40) @(negedge clock);
    issue(W'(0), 32'h1234_5678);
    wait_idle();

    // Start and reset on the same edge: reset wins.
    @(posedge clock); #1;
    multiplicand = W'(9);
    multiplier   = W'(9);
    start        = 1'b1;
    reset        = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("start_with_reset_busy", busy, 0);
    repeat (40) @(negedge clock);

    for (int n = 0; n < 1000; n++) begin
      issue(pick_operand(), pick_operand());
      wait_idle();
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clock);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
